uart_rx: RTL and testbench

//   Serial UART receiver, 8N1 format: 8 data bits, LSB first, no parity, 1 stop bit.

---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
//   Synchronises the async RX line, detects the start edge, samples every bit
//   at its centre and reports each byte with a one-cycle strobe.
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   rx_serial      async serial line, idle high
//   rx_bit         1-cycle strobe: rx_data holds a new good byte
//   rx_data        last good byte, held until the next good byte
//   rx_frame_err   1-cycle strobe: stop bit sampled low
//   rx_parity_err  1-cycle strobe: even-parity mismatch (0 without the macro)
// Build option:
//   UART_RX_PARITY_EN  adds an even parity bit between data bit 7 and stop.
module uart_rx #(
   parameter int CLKS_PER_BIT = 86
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial,
   output logic       rx_bit,
   output logic [7:0] rx_data,
   output logic       rx_frame_err,
   output logic       rx_parity_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      idx;
   logic [7:0]      shift;
   logic [1:0]      sync;
   logic            rxs;

   // Presets to 1 so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], rx_serial};
   end
   assign rxs = sync[1];

`ifdef UART_RX_PARITY_EN
   logic par_bad;
`else
   assign rx_parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         shift        <= '0;
         rx_data      <= '0;
         rx_bit       <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad       <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_bit       <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rxs) state <= START;
            end
            // Sample the start bit at its centre; a high line there was a glitch.
            START: begin
               if (cnt == MID) begin
                  cnt <= '0;
                  if (!rxs) begin
                     state <= DATA;
                     idx   <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt        <= '0;
                  shift[idx] <= rxs;
                  if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == LAST) begin
                  cnt     <= '0;
                  par_bad <= ^{shift, rxs};
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            // Leaving at mid-stop lets a following start bit be caught with no idle gap.
            STOP: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
`ifdef UART_RX_PARITY_EN
                     if (par_bad) begin
                        rx_parity_err <= 1'b1;
                     end else begin
                        rx_data <= shift;
                        rx_bit  <= 1'b1;
                     end
`else
                     rx_data <= shift;
                     rx_bit  <= 1'b1;
`endif
                  end else begin
                     rx_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     rx_parity_err <= par_bad;
`endif
                     state <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // A break / stuck-low line must go high before a new frame is looked for.
            WAIT_HIGH: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int CPB  = 86;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 3 + HALF + 10 * CPB;
`else
   localparam int LAT = 3 + HALF + 9 * CPB;
`endif
   localparam logic [2:0] K_GOOD = 3'b100;
   localparam logic [2:0] K_FERR = 3'b010;
   localparam logic [2:0] K_PERR = 3'b001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_line = 1'b1;
   logic       rx_bit;
   logic [7:0] rx_data;
   logic       rx_frame_err;
   logic       rx_parity_err;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_serial     (rx_line),
      .rx_bit        (rx_bit),
      .rx_data       (rx_data),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err)
   );

   always #50 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe log written only by the monitor; the test reads it by index.
   logic [2:0] ev_kind [0:511];
   logic [7:0] ev_data [0:511];
   int         ev_cyc  [0:511];
   int         wr = 0;
   int         rd = 0;
   int         mon_viol = 0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         if ((rx_bit | rx_frame_err | rx_parity_err) && wr < 512) begin
            ev_kind[wr] = {rx_bit, rx_frame_err, rx_parity_err};
            ev_data[wr] = rx_data;
            ev_cyc[wr]  = cyc;
            wr = wr + 1;
         end
         if (rx_bit && (rx_frame_err || rx_parity_err)) mon_viol = mon_viol + 1;
         if (rx_data != prev_data && !rx_bit) mon_viol = mon_viol + 1;
      end
      prev_data = rx_data;
   end

   int checks = 0;
   int errors = 0;
   int start_cyc = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic expect_ev(input logic [2:0] kind, input logic [7:0] data,
                            input string name, output int lat);
      checks++;
      lat = -1;
      if (rd >= wr) begin
         errors++;
         $display("FAIL %s: got no strobe want kind=%b data=%h", name, kind, data);
      end else begin
         lat = ev_cyc[rd] - start_cyc;
         if (ev_kind[rd] != kind || ev_data[rd] != data) begin
            errors++;
            $display("FAIL %s: got kind=%b data=%h want kind=%b data=%h",
                     name, ev_kind[rd], ev_data[rd], kind, data);
         end
         rd++;
      end
   endtask

   task automatic expect_none(input string name);
      checks++;
      if (rd != wr) begin
         errors++;
         $display("FAIL %s: got %0d unexpected strobes want 0", name, wr - rd);
         rd = wr;
      end
   endtask

   // Called at a negedge; holds the line for one bit time.
   task automatic send_bit(input logic b);
      rx_line = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
      start_cyc = cyc + 1;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ pflip);
`endif
      send_bit(stop);
   endtask

   task automatic idle_bits(input int n);
      rx_line = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         gap;
      logic [2:0] kind;
      logic [7:0] data;
      bit         lat_chk;
   } vec_t;

   vec_t vecs [6];
   int   lat;
   logic [7:0] last_good;
   logic [7:0] b3c;

   initial begin
      vecs[0] = '{8'h3F, 1'b1, 1, K_GOOD, 8'h3F, 1'b1};
      vecs[1] = '{8'hAB, 1'b1, 0, K_GOOD, 8'hAB, 1'b0};
      vecs[2] = '{8'h55, 1'b1, 1, K_GOOD, 8'h55, 1'b0};
      vecs[3] = '{8'h3F, 1'b1, 1, K_GOOD, 8'h3F, 1'b0};
      vecs[4] = '{8'hA5, 1'b0, 1, K_FERR, 8'h3F, 1'b0};
      vecs[5] = '{8'hC3, 1'b1, 1, K_GOOD, 8'hC3, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset_rx_bit", rx_bit, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_frame_err", rx_frame_err, 0);
      chk("reset_parity_err", rx_parity_err, 0);
      rst_n = 1'b1;
      idle_bits(2);
      expect_none("idle_after_reset");

      // Table: single, back-to-back, framing error with held data.
      foreach (vecs[i]) begin
         send_frame(vecs[i].d, vecs[i].stop, 1'b0);
         expect_ev(vecs[i].kind, vecs[i].data, $sformatf("vec%0d", i), lat);
         if (vecs[i].lat_chk) chk("latency", lat, LAT);
         idle_bits(vecs[i].gap);
         if (vecs[i].gap > 0) chk($sformatf("vec%0d_hold", i), rx_data, vecs[i].data);
      end
      last_good = 8'hC3;

      // Good byte, then bad stop followed by a stuck-low line.
      send_frame(8'h3F, 1'b1, 1'b0);
      expect_ev(K_GOOD, 8'h3F, "pre_break", lat);
      send_frame(8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      idle_bits(2);
      expect_ev(K_FERR, 8'h3F, "break_ferr", lat);
      expect_none("break_no_frames");
      chk("break_hold", rx_data, 8'h3F);

      // Low glitch shorter than half a bit, then a 0x00 frame.
      rx_line = 1'b0;
      repeat (20) @(negedge clk);
      idle_bits(2);
      expect_none("glitch");
      send_frame(8'h00, 1'b1, 1'b0);
      expect_ev(K_GOOD, 8'h00, "after_glitch", lat);
      idle_bits(1);

      // Reset in the middle of data bit 4 of 0x3C.
      send_frame(8'h5A, 1'b1, 1'b0);
      expect_ev(K_GOOD, 8'h5A, "pre_reset", lat);
      b3c = 8'h3C;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b3c[i]);
      rx_line = b3c[4];
      repeat (40) @(negedge clk);
      #30 rst_n = 1'b0;
      #1;
      chk("midreset_rx_data", rx_data, 0);
      chk("midreset_rx_bit", rx_bit, 0);
      chk("midreset_frame_err", rx_frame_err, 0);
      @(negedge clk);
      rx_line = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      idle_bits(6);
      expect_none("aborted_frame");
      send_frame(8'hC3, 1'b1, 1'b0);
      expect_ev(K_GOOD, 8'hC3, "post_reset", lat);
      idle_bits(1);
      last_good = 8'hC3;

`ifdef UART_RX_PARITY_EN
      send_frame(8'h3F, 1'b1, 1'b0);
      expect_ev(K_GOOD, 8'h3F, "parity_ok", lat);
      send_frame(8'h3F, 1'b1, 1'b1);
      expect_ev(K_PERR, 8'h3F, "parity_bad", lat);
      idle_bits(1);
      last_good = 8'h3F;
`endif

      // Random frames against a frame-level model.
      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         logic       stop;
         logic       pf;
         logic [2:0] k;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
         pf = ($urandom_range(0, 3) == 0);
`else
         pf = 1'b0;
`endif
         send_frame(d, stop, pf);
         if (stop && !pf) begin
            k = K_GOOD;
            last_good = d;
         end else begin
            k = {1'b0, !stop, pf};
         end
         expect_ev(k, last_good, $sformatf("rand%0d", n), lat);
         if (!stop) idle_bits(1 + $urandom_range(0, 1));
         else       idle_bits($urandom_range(0, 2));
      end
      chk("rand_hold", rx_data, last_good);

      chk("monitor_rules", mon_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
